// File: rtl/servo_sequencer.sv
// rtl/servo_sequencer.sv - gripper servo step sequencer for quarter-turn face moves
//
// Purpose:
//   Accepts one move opcode at a time and plays it out as a fixed sequence
//   of mechanical steps on a set of gripper faces. Each face has a slide
//   servo (grip/retract) and a rotate servo (rest/90 degrees). A move is
//   made of Q quarter turns; each quarter turn is six steps, and each step
//   is held for STEP_CYCLES enabled clock cycles.
//
// Optional feature:
//   SERVO_SEQ_ABORT_EN - adds the abort input, which cancels a move in
//   progress, re-grips every face, unrotates everything and pulses err.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   enable    in   step timer run/freeze (ignored while idle)
//   op_valid  in   opcode present
//   op        in   [FACE_W-1:0] face, [FACE_W+1:FACE_W] type
//                  (00 CW, 01 CCW, 10 half, 11 reserved)
//   abort     in   cancel move (only with SERVO_SEQ_ABORT_EN)
//   op_ready  out  sequencer idle and able to accept an opcode
//   slide     out  per-face slide command, 1 = gripping
//   rot       out  per-face rotate command, 1 = rotated 90 degrees
//   busy      out  move in progress
//   done      out  one-cycle pulse on move completion
//   err       out  one-cycle pulse on rejected opcode (or abort)

module servo_sequencer #(
  parameter int NUM_FACES   = 4,
  parameter int STEP_CYCLES = 50000000,
  parameter int CNT_W       = 26,
  parameter int FACE_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 op_valid,
  input  logic [FACE_W+1:0]    op,
`ifdef SERVO_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 op_ready,
  output logic [NUM_FACES-1:0] slide,
  output logic [NUM_FACES-1:0] rot,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_RETRACT       = 3'd1,
    ST_ROTATE        = 3'd2,
    ST_REGRIP_OTHERS = 3'd3,
    ST_RELEASE       = 3'd4,
    ST_UNROTATE      = 3'd5,
    ST_REGRIP        = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STEP_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_timer, w_timer_nxt;
  logic [1:0]           r_q, w_q_nxt;
  logic [FACE_W-1:0]    r_face, w_face_nxt;
  logic [NUM_FACES-1:0] r_slide, w_slide_nxt;
  logic [NUM_FACES-1:0] r_rot, w_rot_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;
  // Held low by reset so op_ready stays low until the first edge after release.
  logic                 r_live;

  logic [FACE_W-1:0]    w_op_face;
  logic [1:0]           w_op_type;
  logic [1:0]           w_op_q;
  logic                 w_op_bad;
  logic                 w_accept;
  logic                 w_step_end;
  logic [NUM_FACES-1:0] w_op_mask;
  logic [NUM_FACES-1:0] w_face_mask;

  assign w_op_face  = op[FACE_W-1:0];
  assign w_op_type  = op[FACE_W+1:FACE_W];
  assign op_ready   = r_live && (r_state == ST_IDLE);
  assign w_accept   = op_valid && op_ready;
  assign w_step_end = (r_timer == LP_LAST);
  assign w_op_bad   = (w_op_type == 2'b11) || (int'(w_op_face) >= NUM_FACES);

  assign slide = r_slide;
  assign rot   = r_rot;
  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;
  assign err   = r_err;

  // One-hot face masks for the incoming opcode and for the latched face.
  always_comb begin
    w_op_mask   = '0;
    w_face_mask = '0;
    for (int i = 0; i < NUM_FACES; i++) begin
      w_op_mask[i]   = (w_op_face == FACE_W'(i));
      w_face_mask[i] = (r_face == FACE_W'(i));
    end
  end

  // Quarter turns per move: CW is one, half is two, CCW is three CW quarters.
  always_comb begin
    w_op_q = 2'd0;
    case (w_op_type)
      2'b00:   w_op_q = 2'd1;
      2'b01:   w_op_q = 2'd3;
      2'b10:   w_op_q = 2'd2;
      default: w_op_q = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_q_nxt     = r_q;
    w_face_nxt  = r_face;
    w_slide_nxt = r_slide;
    w_rot_nxt   = r_rot;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        if (w_op_bad) begin
          w_err_nxt = 1'b1;
        end else begin
          w_face_nxt  = w_op_face;
          w_q_nxt     = w_op_q;
          w_timer_nxt = '0;
          w_state_nxt = ST_RETRACT;
          // Outputs change on the same edge the step is entered.
          w_slide_nxt = r_slide & w_op_mask;
        end
      end
    end else if (enable) begin
      if (w_step_end) begin
        w_timer_nxt = '0;
        case (r_state)
          ST_RETRACT: begin
            w_state_nxt = ST_ROTATE;
            w_rot_nxt   = r_rot | w_face_mask;
          end
          ST_ROTATE: begin
            w_state_nxt = ST_REGRIP_OTHERS;
            w_slide_nxt = r_slide | ~w_face_mask;
          end
          ST_REGRIP_OTHERS: begin
            w_state_nxt = ST_RELEASE;
            w_slide_nxt = r_slide & ~w_face_mask;
          end
          ST_RELEASE: begin
            w_state_nxt = ST_UNROTATE;
            w_rot_nxt   = r_rot & ~w_face_mask;
          end
          ST_UNROTATE: begin
            w_state_nxt = ST_REGRIP;
            w_slide_nxt = r_slide | w_face_mask;
          end
          ST_REGRIP: begin
            if (r_q > 2'd1) begin
              w_q_nxt     = r_q - 2'd1;
              w_state_nxt = ST_RETRACT;
              w_slide_nxt = r_slide & w_face_mask;
            end else begin
              w_q_nxt     = 2'd0;
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end else begin
        w_timer_nxt = r_timer + CNT_W'(1);
      end
    end

`ifdef SERVO_SEQ_ABORT_EN
    // Abort wins over enable and over any step transition.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_q_nxt     = 2'd0;
      w_slide_nxt = '1;
      w_rot_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_q     <= 2'd0;
      r_face  <= '0;
      r_slide <= '1;
      r_rot   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_q     <= w_q_nxt;
      r_face  <= w_face_nxt;
      r_slide <= w_slide_nxt;
      r_rot   <= w_rot_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_live  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// tb/tb_servo_sequencer.sv - directed bench for servo_sequencer (STEP_CYCLES=4)

module tb_servo_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       op_valid;
  logic [3:0] op;
  logic       op_ready, busy, done, err;
  logic [3:0] slide, rot;

  logic       op_valid3;
  logic [3:0] op3;
  logic       op_ready3, busy3, done3, err3;
  logic [2:0] slide3, rot3;

`ifdef SERVO_SEQ_ABORT_EN
  logic       abort;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  servo_sequencer #(
    .NUM_FACES(4), .STEP_CYCLES(4), .CNT_W(26), .FACE_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .op_valid(op_valid), .op(op),
`ifdef SERVO_SEQ_ABORT_EN
    .abort(abort),
`endif
    .op_ready(op_ready), .slide(slide), .rot(rot),
    .busy(busy), .done(done), .err(err)
  );

  servo_sequencer #(
    .NUM_FACES(3), .STEP_CYCLES(4), .CNT_W(26), .FACE_W(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .enable(enable), .op_valid(op_valid3), .op(op3),
`ifdef SERVO_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .op_ready(op_ready3), .slide(slide3), .rot(rot3),
    .busy(busy3), .done(done3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one opcode at a negedge and follow the move to its done pulse.
  // cnt is 1 in the cycle after the acceptance edge; done is expected at cnt == exp_lat.
  task automatic do_move(input string tag, input logic [3:0] o, input int exp_lat,
                         input logic [3:0] exp_slide1, input logic [3:0] exp_rot5,
                         input int exp_pulses, input int freeze_at);
    int cnt;
    int pulses;
    logic [3:0] prev;
    logic [3:0] slide1;
    logic [3:0] rot5;
    op = o;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    cnt = 1;
    slide1 = slide;
    prev = rot;
    rot5 = 4'h0;
    pulses = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready_lo"}, 32'(op_ready), 32'd0);
    while (!done && cnt < 400) begin
      if (cnt == 5) rot5 = rot;
      if (cnt == freeze_at) begin
        enable = 1'b0;
        repeat (10) begin
          @(negedge clk);
          cnt++;
        end
        check({tag, "_frz_rot"}, 32'(rot), 32'(exp_rot5));
        check({tag, "_frz_busy"}, 32'(busy), 32'd1);
        enable = 1'b1;
      end
      @(negedge clk);
      cnt++;
      if ((rot & ~prev) != 4'h0) pulses++;
      prev = rot;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_slide_retract"}, 32'(slide1), 32'(exp_slide1));
    check({tag, "_rot_rotate"}, 32'(rot5), 32'(exp_rot5));
    check({tag, "_rot_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, "_final_slide"}, 32'(slide), 32'hf);
    check({tag, "_final_rot"}, 32'(rot), 32'h0);
    check({tag, "_final_ready"}, 32'(op_ready), 32'd1);
    check({tag, "_err_lo"}, 32'(err), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    enable = 1'b1;
    op_valid = 1'b0;
    op = 4'h0;
    op_valid3 = 1'b0;
    op3 = 4'h0;
`ifdef SERVO_SEQ_ABORT_EN
    abort = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_slide", 32'(slide), 32'hf);
    check("rst_rot", 32'(rot), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(op_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(op_ready), 32'd1);

    // CW face 1, then CCW face 2 accepted in the done cycle, then half face 0
    do_move("cw1", 4'b0001, 25, 4'b0010, 4'b0010, 1, 0);
    do_move("ccw2", 4'b0110, 73, 4'b0100, 4'b0100, 3, 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    do_move("half0", 4'b1000, 49, 4'b0001, 4'b0001, 2, 0);
    @(negedge clk);

    // Reserved opcode and out-of-range face on the 3-face instance
    op = 4'b1100;
    op_valid = 1'b1;
    op3 = 4'b0011;
    op_valid3 = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    op_valid3 = 1'b0;
    check("rsv_err", 32'(err), 32'd1);
    check("rsv_busy", 32'(busy), 32'd0);
    check("rsv_slide", 32'(slide), 32'hf);
    check("rsv_rot", 32'(rot), 32'h0);
    check("rsv_done", 32'(done), 32'd0);
    check("f3_err", 32'(err3), 32'd1);
    check("f3_busy", 32'(busy3), 32'd0);
    @(negedge clk);
    check("rsv_err_pulse", 32'(err), 32'd0);
    check("f3_err_pulse", 32'(err3), 32'd0);

    // Enable low for 10 cycles in ROTATE
    do_move("frz1", 4'b0001, 35, 4'b0010, 4'b0010, 1, 6);
    @(negedge clk);

    // Reset pulse during RELEASE of CW face 2
    op = 4'b0010;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("rel_slide", 32'(slide), 32'hb);
    rst = 1'b0;
    #1;
    check("mid_rst_slide", 32'(slide), 32'hf);
    check("mid_rst_rot", 32'(rot), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);
    do_move("post_rst", 4'b0011, 25, 4'b1000, 4'b1000, 1, 0);
    @(negedge clk);

`ifdef SERVO_SEQ_ABORT_EN
    // Abort during UNROTATE of CW face 0
    op = 4'b0000;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("unrot_rot", 32'(rot), 32'h0);
    check("unrot_slide", 32'(slide), 32'he);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_slide", 32'(slide), 32'hf);
    check("abort_rot", 32'(rot), 32'h0);
    check("abort_err", 32'(err), 32'd1);
    check("abort_ready", 32'(op_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
